mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction read
// port (i_*), a data read port (dr_*) and a data write port (dw_*).
//
// Arbitration is fixed priority dw > dr > i. An instruction request that
// has been refused STARVE_LIMIT consecutive cycles wins over both data
// ports. Grants and the m_* strobe are combinational from the current
// requests. Read data returns one cycle after the grant on rdata, with
// exactly one of i_rresp / dr_rresp marking the owner.
//
// Accesses whose address has bits set above AW-1 never reach memory. They
// raise addr_err one cycle later, and reads still complete with rdata = 0.
//
// Optional build macro MMIO_DECODE_EN: writes to MMIO_PUTC / MMIO_EXIT are
// absorbed and become putc_valid/putc_char and exit_valid pulses. Without
// the macro those outputs are tied to 0 and MMIO addresses are ordinary
// (out-of-range) accesses.
//
// Ports:
//   clk, resetb                  clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt/i_rresp   instruction read port
//   dr_req/dr_addr/dr_gnt/dr_rresp  data read port
//   dw_req/dw_addr/dw_wdata/dw_wstrb/dw_gnt  data write port
//   rdata                        shared read data
//   m_req/m_we/m_addr/m_wdata/m_wstrb/m_rdata  memory side
//   putc_valid/putc_char/exit_valid  MMIO side effects
//   addr_err                     out-of-range access pulse
module mem_arbiter #(
   parameter int unsigned AW           = 18,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] MMIO_PUTC    = 32'h8000_001c,
   parameter logic [31:0] MMIO_EXIT    = 32'h8000_002c
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic          i_req,
   input  logic [31:0]   i_addr,
   output logic          i_gnt,
   output logic          i_rresp,
   input  logic          dr_req,
   input  logic [31:0]   dr_addr,
   output logic          dr_gnt,
   output logic          dr_rresp,
   output logic [31:0]   rdata,
   input  logic          dw_req,
   input  logic [31:0]   dw_addr,
   input  logic [31:0]   dw_wdata,
   input  logic [3:0]    dw_wstrb,
   output logic          dw_gnt,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-3:0] m_addr,
   output logic [31:0]   m_wdata,
   output logic [3:0]    m_wstrb,
   input  logic [31:0]   m_rdata,
   output logic          putc_valid,
   output logic [7:0]    putc_char,
   output logic          exit_valid,
   output logic          addr_err
);

   localparam int unsigned SCW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

   typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_I = 2'd1, SEL_DR = 2'd2, SEL_DW = 2'd3} sel_e;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_DR = 2'd2} own_e;

   // True when the byte address lies inside the 2**AW byte memory window.
   function automatic logic addr_in_range(input logic [31:0] addr);
      return ((addr >> AW) == 32'd0);
   endfunction

   sel_e            sel_s;
   logic [31:0]     acc_addr_s;
   logic            acc_valid_s;
   logic            acc_write_s;
   logic            putc_hit_s;
   logic            exit_hit_s;
   logic            mmio_hit_s;
   logic            err_s;
   logic            mem_go_s;

   logic [SCW-1:0]  starve_cnt_r;
   own_e            owner_r;
   logic            rd_err_r;
   logic            addr_err_r;

   // Winner selection; a starved instruction request overrides the data ports.
   always_comb begin
      sel_s = SEL_NONE;
      if (!resetb) begin
         sel_s = SEL_NONE;
      end else if (i_req && (starve_cnt_r == STARVE_MAX)) begin
         sel_s = SEL_I;
      end else if (dw_req) begin
         sel_s = SEL_DW;
      end else if (dr_req) begin
         sel_s = SEL_DR;
      end else if (i_req) begin
         sel_s = SEL_I;
      end else begin
         sel_s = SEL_NONE;
      end
   end

   // Decode the granted access into memory, MMIO or error.
   always_comb begin
      acc_addr_s  = 32'd0;
      acc_valid_s = 1'b0;
      acc_write_s = 1'b0;
      putc_hit_s  = 1'b0;
      exit_hit_s  = 1'b0;
      case (sel_s)
         SEL_I: begin
            acc_addr_s  = i_addr;
            acc_valid_s = 1'b1;
         end
         SEL_DR: begin
            acc_addr_s  = dr_addr;
            acc_valid_s = 1'b1;
         end
         SEL_DW: begin
            acc_addr_s  = dw_addr;
            acc_valid_s = 1'b1;
            acc_write_s = 1'b1;
         end
         default: begin
            acc_addr_s  = 32'd0;
            acc_valid_s = 1'b0;
         end
      endcase
`ifdef MMIO_DECODE_EN
      if (acc_write_s) begin
         putc_hit_s = (acc_addr_s == MMIO_PUTC);
         exit_hit_s = (acc_addr_s == MMIO_EXIT);
      end else begin
         putc_hit_s = 1'b0;
         exit_hit_s = 1'b0;
      end
`endif
      mmio_hit_s = putc_hit_s | exit_hit_s;
      err_s      = acc_valid_s && !mmio_hit_s && !addr_in_range(acc_addr_s);
      mem_go_s   = acc_valid_s && !mmio_hit_s && addr_in_range(acc_addr_s);
   end

   assign i_gnt   = (sel_s == SEL_I);
   assign dr_gnt  = (sel_s == SEL_DR);
   assign dw_gnt  = (sel_s == SEL_DW);
   assign m_req   = mem_go_s;
   assign m_we    = mem_go_s && acc_write_s;
   assign m_addr  = mem_go_s ? acc_addr_s[AW-1:2] : {(AW-2){1'b0}};
   assign m_wdata = (mem_go_s && acc_write_s) ? dw_wdata : 32'd0;
   assign m_wstrb = (mem_go_s && acc_write_s) ? dw_wstrb : 4'd0;

   // Count consecutive refused instruction requests, saturating at the limit.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         starve_cnt_r <= {SCW{1'b0}};
      end else if (i_req && (sel_s != SEL_I)) begin
         if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_r <= starve_cnt_r + SCW'(1);
         end
      end else begin
         starve_cnt_r <= {SCW{1'b0}};
      end
   end

   // Remember who owns the read returning next cycle and whether it faulted.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         owner_r    <= OWN_NONE;
         rd_err_r   <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         case (sel_s)
            SEL_I:   owner_r <= OWN_I;
            SEL_DR:  owner_r <= OWN_DR;
            default: owner_r <= OWN_NONE;
         endcase
         rd_err_r   <= err_s && !acc_write_s;
         addr_err_r <= err_s;
      end
   end

   assign i_rresp  = (owner_r == OWN_I);
   assign dr_rresp = (owner_r == OWN_DR);
   assign addr_err = addr_err_r;
   // Faulted reads return zero instead of whatever the memory last drove.
   assign rdata    = ((owner_r != OWN_NONE) && !rd_err_r) ? m_rdata : 32'd0;

`ifdef MMIO_DECODE_EN
   logic       putc_valid_r;
   logic [7:0] putc_char_r;
   logic       exit_valid_r;

   // One-cycle MMIO side-effect pulses following an absorbed write.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         putc_valid_r <= 1'b0;
         putc_char_r  <= 8'd0;
         exit_valid_r <= 1'b0;
      end else begin
         putc_valid_r <= putc_hit_s;
         putc_char_r  <= putc_hit_s ? dw_wdata[7:0] : 8'd0;
         exit_valid_r <= exit_hit_s;
      end
   end

   assign putc_valid = putc_valid_r;
   assign putc_char  = putc_char_r;
   assign exit_valid = exit_valid_r;
`else
   assign putc_valid = 1'b0;
   assign putc_char  = 8'd0;
   assign exit_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (default parameters). Directed
// stimulus pushes expected grants and expected responses into queues; a
// negedge monitor pops and compares whenever the DUT presents something.
module tb_mem_arbiter;

   localparam int AW = 18;

   typedef struct packed {
      logic i_gnt;
      logic dr_gnt;
      logic dw_gnt;
      logic m_req;
   } gnt_t;

   typedef struct packed {
      logic        i_rresp;
      logic        dr_rresp;
      logic        addr_err;
      logic        putc_valid;
      logic        exit_valid;
      logic [7:0]  putc_char;
      logic [31:0] rdata;
   } rsp_t;

   localparam gnt_t G_I     = 4'b1001;
   localparam gnt_t G_DR    = 4'b0101;
   localparam gnt_t G_DW    = 4'b0011;
   localparam gnt_t G_I_NM  = 4'b1000;
   localparam gnt_t G_DR_NM = 4'b0100;
   localparam gnt_t G_DW_NM = 4'b0010;

   logic          clk = 1'b0;
   logic          resetb;
   logic          i_req, dr_req, dw_req;
   logic [31:0]   i_addr, dr_addr, dw_addr, dw_wdata;
   logic [3:0]    dw_wstrb;
   logic          i_gnt, i_rresp, dr_gnt, dr_rresp, dw_gnt;
   logic [31:0]   rdata;
   logic          m_req, m_we;
   logic [AW-3:0] m_addr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wstrb;
   logic [31:0]   m_rdata;
   logic          putc_valid, exit_valid, addr_err;
   logic [7:0]    putc_char;

   logic [31:0]   mem [0:(1<<(AW-2))-1];

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   mem_arbiter #(.AW(AW)) dut (
      .clk(clk), .resetb(resetb),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rresp(i_rresp),
      .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_rresp(dr_rresp),
      .rdata(rdata),
      .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_wstrb(dw_wstrb),
      .dw_gnt(dw_gnt),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_rdata(m_rdata),
      .putc_valid(putc_valid), .putc_char(putc_char), .exit_valid(exit_valid),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   // Single-port memory model: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (m_req) begin
         if (m_we) begin
            for (int b = 0; b < 4; b++) begin
               if (m_wstrb[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end
         end else begin
            m_rdata <= mem[m_addr];
         end
      end
   end

   // Monitor: reset-state check, grant check, response check.
   always @(negedge clk) begin
      gnt_t ga, ge;
      rsp_t ra, re;
      if (!resetb) begin
         n_total++;
         if ({i_gnt, i_rresp, dr_gnt, dr_rresp, rdata, dw_gnt, m_req, m_we, m_addr,
              m_wdata, m_wstrb, putc_valid, putc_char, exit_valid, addr_err} == '0)
            n_pass++;
         else
            $display("FAIL reset_outputs: gnt=%b%b%b m_req=%b rresp=%b%b rdata=%h addr_err=%b, required all 0",
                     i_gnt, dr_gnt, dw_gnt, m_req, i_rresp, dr_rresp, rdata, addr_err);
      end else begin
         ga = {i_gnt, dr_gnt, dw_gnt, m_req};
         if (i_req || dr_req || dw_req || (ga != 4'b0000)) begin
            n_total++;
            if (gnt_q.size() == 0) begin
               $display("FAIL grant: got i/dr/dw/m=%b, required no activity", ga);
            end else begin
               ge = gnt_q.pop_front();
               if (ga == ge) n_pass++;
               else $display("FAIL grant: got i/dr/dw/m=%b, required %b", ga, ge);
            end
         end
         ra = {i_rresp, dr_rresp, addr_err, putc_valid, exit_valid, putc_char, rdata};
         if (i_rresp || dr_rresp || addr_err || putc_valid || exit_valid) begin
            n_total++;
            if (rsp_q.size() == 0) begin
               $display("FAIL response: got %h, required none", ra);
            end else begin
               re = rsp_q.pop_front();
               // Payload fields only matter when their strobe is expected.
               if (!re.putc_valid) begin ra.putc_char = 8'd0; re.putc_char = 8'd0; end
               if (!(re.i_rresp || re.dr_rresp)) begin ra.rdata = 32'd0; re.rdata = 32'd0; end
               if (ra == re) n_pass++;
               else $display("FAIL response: got i/dr/err/putc/exit=%b%b%b%b%b char=%h rdata=%h, required %b%b%b%b%b char=%h rdata=%h",
                             ra.i_rresp, ra.dr_rresp, ra.addr_err, ra.putc_valid, ra.exit_valid, ra.putc_char, ra.rdata,
                             re.i_rresp, re.dr_rresp, re.addr_err, re.putc_valid, re.exit_valid, re.putc_char, re.rdata);
            end
         end
      end
   end

   function automatic rsp_t mk_rsp(input logic ir, input logic dr, input logic ae,
                                   input logic pv, input logic ev, input logic [7:0] pc,
                                   input logic [31:0] rd);
      rsp_t r;
      r = {ir, dr, ae, pv, ev, pc, rd};
      return r;
   endfunction

   // Drive one cycle of requests (just after posedge) and queue the expected grant.
   task automatic cyc(input logic ir, input logic [31:0] ia,
                      input logic drr, input logic [31:0] dra,
                      input logic dwr, input logic [31:0] dwa,
                      input logic [31:0] wd, input logic [3:0] ws, input gnt_t eg);
      i_req = ir; i_addr = ia; dr_req = drr; dr_addr = dra;
      dw_req = dwr; dw_addr = dwa; dw_wdata = wd; dw_wstrb = ws;
      if (ir || drr || dwr) gnt_q.push_back(eg);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, G_I);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int leftover;
      for (int a = 0; a < (1 << (AW-2)); a++) mem[a] = 32'd0;
      mem[16'h0040] = 32'hdeadbeef;
      mem[16'h0041] = 32'h0badf00d;
      mem[16'h0080] = 32'h12345678;
      mem[16'hffff] = 32'hcafef00d;
      m_rdata = 32'd0;

      // Reset with every requester active: grants must stay low.
      resetb = 1'b0;
      i_req = 1'b1; i_addr = 32'h100; dr_req = 1'b1; dr_addr = 32'h100;
      dw_req = 1'b1; dw_addr = 32'h100; dw_wdata = 32'hffffffff; dw_wstrb = 4'hf;
      repeat (3) @(posedge clk);
      #1;
      i_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0;
      resetb = 1'b1;
      idle(1);

      // Plain data read.
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'hdeadbeef));
      cyc(1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, G_DR);
      idle(1);

      // All three at once: dw, then dr, then i; reads back-to-back.
      cyc(1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h300, 32'h11223344, 4'hf, G_DW);
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0badf00d));
      cyc(1'b1, 32'h200, 1'b1, 32'h104, 1'b0, 32'd0, 32'd0, 4'd0, G_DR);
      rsp_q.push_back(mk_rsp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h12345678));
      cyc(1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, G_I);
      idle(1);

      // Partial-strobe write over 0x11223344, then read it back.
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300, 32'haabbccdd, 4'b0101, G_DW);
      rsp_q.push_back(mk_rsp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h11bb33dd));
      cyc(1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, G_I);
      idle(1);

      // Starvation: dr held 10 cycles, i refused 4 times then wins on cycle 4.
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            rsp_q.push_back(mk_rsp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h12345678));
            cyc(1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, G_I);
         end else begin
            rsp_q.push_back(mk_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'hdeadbeef));
            cyc((k < 4), 32'h200, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, G_DR);
         end
      end
      idle(1);

      // Address range: out of range read/write, top word in range.
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0));
      cyc(1'b0, 32'd0, 1'b1, 32'h0010_0000, 1'b0, 32'd0, 32'd0, 4'd0, G_DR_NM);
      rsp_q.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0));
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0004_0000, 32'h5555aaaa, 4'hf, G_DW_NM);
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'hcafef00d));
      cyc(1'b0, 32'd0, 1'b1, 32'h0003_fffc, 1'b0, 32'd0, 32'd0, 4'd0, G_DR);
      rsp_q.push_back(mk_rsp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0));
      cyc(1'b1, 32'h0004_0000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, G_I_NM);
      idle(1);

      // MMIO writes never touch memory.
`ifdef MMIO_DECODE_EN
      rsp_q.push_back(mk_rsp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 32'h0));
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_001c, 32'h0000_0041, 4'h1, G_DW_NM);
      rsp_q.push_back(mk_rsp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0));
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_002c, 32'h0000_0000, 4'hf, G_DW_NM);
`else
      rsp_q.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0));
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_001c, 32'h0000_0041, 4'h1, G_DW_NM);
      rsp_q.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0));
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_002c, 32'h0000_0000, 4'hf, G_DW_NM);
`endif
      idle(1);

      // Reset right after a read grant: that read must never respond.
      cyc(1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, G_DR);
      i_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0;
      resetb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetb = 1'b1;
      idle(4);

      // Normal operation resumes.
      rsp_q.push_back(mk_rsp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0badf00d));
      cyc(1'b1, 32'h104, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, G_I);
      idle(3);

      leftover = gnt_q.size() + rsp_q.size();
      if (leftover != 0)
         $display("FAIL drain: %0d expected events never seen, required 0", leftover);
      $display("%0d/%0d checks passed", n_pass, n_total + leftover);
      $finish;
   end

endmodule
